axis2avl_bridge: RTL and testbench
==================================

Name: axis2avl_bridge

Overview:
- Parametrised AXI4-Stream slave to Avalon-ST source bridge; next generation of the single-channel converter that feeds the FIR core.
- Adds byte-enable to EMPTY translation, multi-channel TDEST to CHANNEL mapping, a configurable-depth elastic FIFO and max-packet-length truncation.
- Sits between the external AXI-ST ingress and any Avalon-ST DSP core, such as the FIR.

Parameters:
- DATA_WIDTH, 16, data bus width in bits; must be a multiple of 8, from 8 to 256.
- CH_WIDTH, 2, width of TDEST and CHANNEL; up to 2^CH_WIDTH channels.
- FIFO_DEPTH, 8, number of buffered beats; power of 2, minimum 2.
- MAX_PKT_LEN, 1000, maximum number of beats per packet before forced truncation.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8) (minimum 1), width of the EMPTY output.

Ports:
- S_AXIS_ACLK  in  1  single clock for the whole block.
- S_AXIS_ARESETN  in  1  asynchronous active-low reset.
- S_AXIS_TREADY  out  1  bridge accepts a beat.
- S_AXIS_TDATA  in  DATA_WIDTH  input data.
- S_AXIS_TKEEP  in  DATA_WIDTH/8  byte enables; contiguous and low-aligned.
- S_AXIS_TLAST  in  1  last beat of packet.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TDEST  in  CH_WIDTH  destination channel.
- DATA_INPUT_READY  in  1  Avalon sink ready (readyLatency 0).
- DATA_INPUT_VALID  out  1  Avalon beat valid.
- DATA_INPUT_STARTOFPACKET  out  1  start of packet.
- DATA_INPUT_ENDOFPACKET  out  1  end of packet.
- DATA_INPUT_DATA  out  DATA_WIDTH  output data.
- DATA_INPUT_EMPTY  out  EMPTY_WIDTH  unused bytes on the EOP beat.
- DATA_INPUT_CHANNEL  out  CH_WIDTH  channel of the packet.
- PKT_TRUNC  out  1  one-cycle pulse when a packet is truncated.
- KEEP_ERR  out  1  one-cycle pulse when a non-last beat has TKEEP not all ones.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: asynchronous on S_AXIS_ARESETN low.
  - All outputs go to 0; FIFO is emptied; state goes to S_SOP; beat counter is cleared.
  - S_AXIS_TREADY rises the first cycle after reset release.
- Input handshake: a beat is accepted when TVALID && TREADY.
  - TREADY = !full in S_SOP and S_BODY; TREADY = 1 in S_DROP.
- State machine (S_SOP, S_BODY, S_DROP):
  - S_SOP: on an accepted beat, write it with sop=1 and latch TDEST as the packet channel. If TLAST=1, stay in S_SOP (single-beat packet); otherwise go to S_BODY.
  - S_BODY: write accepted beats with sop=0 and the latched channel; TDEST changes mid-packet are ignored. On TLAST, go to S_SOP.
  - Truncation: the beat counter counts beats written for the current packet. If the MAX_PKT_LEN-th beat has TLAST=0:
    - write it with eop=1, EMPTY=0;
    - pulse PKT_TRUNC;
    - go to S_DROP.
  - S_DROP: accepted beats are discarded (not written). On an accepted TLAST, go to S_SOP.
- EMPTY on an eop beat written from TLAST = count of zero bits in TKEEP. EMPTY is 0 on all other beats.
- KEEP_ERR pulses on any accepted non-last beat whose TKEEP is not all ones; the beat is still written.
- FIFO: synchronous, first-word fall-through.
  - DATA_INPUT_VALID = !empty.
  - Pop on VALID && READY.
  - Latency: beat accepted in cycle N appears on the Avalon outputs in cycle N+1 when the FIFO was empty.
- Simultaneous push and pop: permitted when not full; level is unchanged.
- Full: TREADY=0 (except in S_DROP). No push occurs that cycle, even if a pop occurs; TREADY recovers the next cycle.
- Empty: VALID=0; DATA, SOP, EOP, EMPTY and CHANNEL hold their last values.
- Full sustained throughput is 1 beat/cycle.
- Reset mid-packet: remainder of the packet is lost; the next accepted beat is marked SOP.

Optional Feature:
- Macro AXIS2AVL_BIST_EN.
- When defined:
  - Adds input BIST_MODE (1 bit).
  - While BIST_MODE=1, the AXI input is ignored and TREADY=0.
  - An internal 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reseeded on BIST_MODE rising edge) writes MAX_PKT_LEN-beat packets on channel 0.
  - LFSR data is zero-extended or truncated to DATA_WIDTH; TKEEP is treated as all ones.
  - Generation respects FIFO full.
- When not defined: no port, no LFSR logic; behaviour is exactly as above.

Decomposition:
- Package axis_avl_pkg:
  - state enum (S_SOP, S_BODY, S_DROP);
  - beat struct {data, sop, eop, empty, channel};
  - LFSR seed and polynomial constants;
  - function converting TKEEP to EMPTY count.
- Sub-module axis_sync_fifo: generic FWFT FIFO parametrised by payload width and depth, providing level, full and empty.

Test Plan:
- 4-beat packet, DATA_WIDTH=16, TDEST=2, READY=1 -> beats 1..4 out starting at N+1; SOP on beat 1, EOP on beat 4, CHANNEL=2, EMPTY=0.
- DATA_WIDTH=32, single beat with TLAST=1 and TKEEP=4'b0011 -> SOP=EOP=1, EMPTY=2.
- FIFO_DEPTH=8, READY=0, 10 beats offered -> 8 accepted; TREADY low from 9th; FIFO_LEVEL=8. Then READY=1 -> all 10 out in order, none lost.
- MAX_PKT_LEN=8, 12-beat packet followed by a 3-beat packet:
  - 8 beats out, EOP on beat 8, one PKT_TRUNC pulse;
  - beats 9-12 dropped with TREADY=1;
  - next packet SOP correct.
- TDEST changes from 1 to 3 on beat 2 of a 3-beat packet -> all three beats show CHANNEL=1.
- ARESETN pulsed low after beat 2 of 5 -> outputs 0, FIFO_LEVEL=0; the next accepted beat carries SOP=1.

Source files
------------

// File: rtl/axis_avl_pkg.sv
// Shared types and helpers for the AXI4-Stream to Avalon-ST bridge.
// Holds the packet FSM state enum, LFSR constants and TKEEP->EMPTY count.
package axis_avl_pkg;

   typedef enum logic [1:0] {
      S_SOP,
      S_BODY,
      S_DROP
   } state_t;

   // Flag part of a buffered beat; data/empty/channel widths are
   // per-instance, so the full beat struct is built in the bridge.
   typedef struct packed {
      logic sop;
      logic eop;
   } beat_flags_t;

   // x^16+x^14+x^13+x^11+1, right-shifting Galois form
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   // Number of unused bytes in a low-aligned TKEEP of nbytes lanes
   function automatic int keep_zeros(input logic [31:0] keep,
                                     input int nbytes);
      int z;
      z = 0;
      for (int i = 0; i < 32; i++)
         if (i < nbytes && !keep[i])
            z++;
      return z;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports: clk/rst_n, push/wdata, pop/rdata (head), level, full, empty.
module axis_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic [AW:0]      cnt;
   logic             wr;
   logic             rd;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign rdata = mem[rp];
   assign level = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr)
            wp <= wp + AW'(1);
         if (rd)
            rp <= rp + AW'(1);
         if (wr && !rd)
            cnt <= cnt + (AW+1)'(1);
         else if (rd && !wr)
            cnt <= cnt - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wp] <= wdata;
   end

endmodule

// File: rtl/axis2avl_bridge.sv
// AXI4-Stream slave to Avalon-ST source bridge with channel mapping,
// elastic FIFO, TKEEP->EMPTY and max-length truncation.
// Ports: S_AXIS_* ingress, DATA_INPUT_* Avalon egress, PKT_TRUNC and
// KEEP_ERR pulses, FIFO_LEVEL. AXIS2AVL_BIST_EN adds BIST_MODE + LFSR.
module axis2avl_bridge
   import axis_avl_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int CH_WIDTH    = 2,
   parameter int FIFO_DEPTH  = 8,
   parameter int MAX_PKT_LEN = 1000,
   parameter int EMPTY_WIDTH =
      (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH/8) : 1
) (
   input  logic                          S_AXIS_ACLK,
   input  logic                          S_AXIS_ARESETN,
`ifdef AXIS2AVL_BIST_EN
   input  logic                          BIST_MODE,
`endif
   output logic                          S_AXIS_TREADY,
   input  logic [DATA_WIDTH-1:0]         S_AXIS_TDATA,
   input  logic [DATA_WIDTH/8-1:0]       S_AXIS_TKEEP,
   input  logic                          S_AXIS_TLAST,
   input  logic                          S_AXIS_TVALID,
   input  logic [CH_WIDTH-1:0]           S_AXIS_TDEST,
   input  logic                          DATA_INPUT_READY,
   output logic                          DATA_INPUT_VALID,
   output logic                          DATA_INPUT_STARTOFPACKET,
   output logic                          DATA_INPUT_ENDOFPACKET,
   output logic [DATA_WIDTH-1:0]         DATA_INPUT_DATA,
   output logic [EMPTY_WIDTH-1:0]        DATA_INPUT_EMPTY,
   output logic [CH_WIDTH-1:0]           DATA_INPUT_CHANNEL,
   output logic                          PKT_TRUNC,
   output logic                          KEEP_ERR,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

   localparam int KW   = DATA_WIDTH/8;
   localparam int CNTW = $clog2(MAX_PKT_LEN+1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  data;
      beat_flags_t            flags;
      logic [EMPTY_WIDTH-1:0] empty;
      logic [CH_WIDTH-1:0]    channel;
   } beat_t;

   state_t              state;
   logic [CNTW-1:0]     cnt;
   logic [CNTW-1:0]     idx;
   logic [CH_WIDTH-1:0] ch_q;
   logic                rdy_q;
   logic                at_max;
   logic                axi_en;
   logic                tready_core;
   logic                acc;
   logic                push;
   logic                pop;
   logic                trunc;
   logic                full;
   logic                empty;
   beat_t               wr_beat;
   beat_t               head;
   beat_t               last_q;
   beat_t               shown;

   logic                  src_valid;
   logic [DATA_WIDTH-1:0] src_data;
   logic [KW-1:0]         src_keep;
   logic                  src_last;
   logic [CH_WIDTH-1:0]   src_dest;

`ifdef AXIS2AVL_BIST_EN
   logic        bist_q;
   logic [15:0] lfsr;
   assign axi_en = !BIST_MODE;
`else
   assign axi_en = 1'b1;
`endif

   // Position of the beat being offered within the current packet
   assign idx    = (state == S_SOP) ? CNTW'(1) : cnt + CNTW'(1);
   assign at_max = (idx == CNTW'(MAX_PKT_LEN));

   // rdy_q holds TREADY low for the first cycle after reset release
   assign tready_core   = rdy_q && (state == S_DROP || !full);
   assign S_AXIS_TREADY = tready_core && axi_en;

   always_comb begin
      src_valid = S_AXIS_TVALID && axi_en;
      src_data  = S_AXIS_TDATA;
      src_keep  = S_AXIS_TKEEP;
      src_last  = S_AXIS_TLAST;
      src_dest  = S_AXIS_TDEST;
`ifdef AXIS2AVL_BIST_EN
      if (BIST_MODE) begin
         // generator starts the cycle after the reseed
         src_valid = bist_q;
         src_data  = DATA_WIDTH'(lfsr);
         src_keep  = '1;
         src_last  = at_max;
         src_dest  = '0;
      end
`endif
   end

   assign acc   = src_valid && tready_core;
   assign push  = acc && (state != S_DROP);
   assign trunc = push && at_max && !src_last;

   always_comb begin
      wr_beat.data       = src_data;
      wr_beat.flags.sop  = (state == S_SOP);
      wr_beat.flags.eop  = src_last || at_max;
      wr_beat.empty      = '0;
      if (src_last)
         wr_beat.empty = EMPTY_WIDTH'(keep_zeros(32'(src_keep), KW));
      wr_beat.channel    = (state == S_SOP) ? src_dest : ch_q;
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state     <= S_SOP;
         cnt       <= '0;
         ch_q      <= '0;
         rdy_q     <= 1'b0;
         PKT_TRUNC <= 1'b0;
         KEEP_ERR  <= 1'b0;
         last_q    <= '0;
      end else begin
         rdy_q     <= 1'b1;
         PKT_TRUNC <= trunc;
         KEEP_ERR  <= acc && !src_last && (src_keep != '1);
         if (pop)
            last_q <= head;
         if (acc) begin
            if (state == S_DROP) begin
               if (src_last)
                  state <= S_SOP;
            end else begin
               cnt <= idx;
               if (state == S_SOP)
                  ch_q <= src_dest;
               if (trunc)
                  state <= S_DROP;
               else if (src_last)
                  state <= S_SOP;
               else
                  state <= S_BODY;
            end
         end
`ifdef AXIS2AVL_BIST_EN
         if (BIST_MODE && !bist_q) begin
            state <= S_SOP;
            cnt   <= '0;
         end
`endif
      end
   end

`ifdef AXIS2AVL_BIST_EN
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         bist_q <= 1'b0;
         lfsr   <= LFSR_SEED;
      end else begin
         bist_q <= BIST_MODE;
         if (BIST_MODE && !bist_q)
            lfsr <= LFSR_SEED;
         else if (BIST_MODE && acc)
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
      end
   end
`endif

   axis_sync_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (S_AXIS_ACLK),
      .rst_n (S_AXIS_ARESETN),
      .push  (push),
      .wdata (wr_beat),
      .pop   (pop),
      .rdata (head),
      .level (FIFO_LEVEL),
      .full  (full),
      .empty (empty)
   );

   assign pop   = !empty && DATA_INPUT_READY;
   // outputs hold the last popped beat while the FIFO is empty
   assign shown = empty ? last_q : head;

   assign DATA_INPUT_VALID         = !empty;
   assign DATA_INPUT_STARTOFPACKET = shown.flags.sop;
   assign DATA_INPUT_ENDOFPACKET   = shown.flags.eop;
   assign DATA_INPUT_DATA          = shown.data;
   assign DATA_INPUT_EMPTY         = shown.empty;
   assign DATA_INPUT_CHANNEL       = shown.channel;

endmodule

// File: tb/tb_axis2avl_bridge.sv
// Self-checking bench for axis2avl_bridge (32-bit data, depth 8,
// 8-beat packet limit) with a packet-level expectation queue.
module tb_axis2avl_bridge;

   localparam int DW    = 32;
   localparam int CW    = 2;
   localparam int DEPTH = 8;
   localparam int MAXL  = 8;
   localparam int EW    = 2;
   localparam int KW    = DW/8;
   localparam int LW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tready;
   logic [DW-1:0] tdata = '0;
   logic [KW-1:0] tkeep = '0;
   logic          tlast = 1'b0;
   logic          tvalid = 1'b0;
   logic [CW-1:0] tdest = '0;
   logic          aready = 1'b0;
   logic          avalid;
   logic          asop;
   logic          aeop;
   logic [DW-1:0] adata;
   logic [EW-1:0] aempty;
   logic [CW-1:0] ach;
   logic          ptrunc;
   logic          kerr;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   axis2avl_bridge #(
      .DATA_WIDTH  (DW),
      .CH_WIDTH    (CW),
      .FIFO_DEPTH  (DEPTH),
      .MAX_PKT_LEN (MAXL),
      .EMPTY_WIDTH (EW)
   ) dut (
      .S_AXIS_ACLK              (clk),
      .S_AXIS_ARESETN           (rst_n),
      .S_AXIS_TREADY            (tready),
      .S_AXIS_TDATA             (tdata),
      .S_AXIS_TKEEP             (tkeep),
      .S_AXIS_TLAST             (tlast),
      .S_AXIS_TVALID            (tvalid),
      .S_AXIS_TDEST             (tdest),
      .DATA_INPUT_READY         (aready),
      .DATA_INPUT_VALID         (avalid),
      .DATA_INPUT_STARTOFPACKET (asop),
      .DATA_INPUT_ENDOFPACKET   (aeop),
      .DATA_INPUT_DATA          (adata),
      .DATA_INPUT_EMPTY         (aempty),
      .DATA_INPUT_CHANNEL       (ach),
      .PKT_TRUNC                (ptrunc),
      .KEEP_ERR                 (kerr),
      .FIFO_LEVEL               (level)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic [EW-1:0] empty;
      logic [CW-1:0] ch;
   } exp_t;

   exp_t expq[$];
   int   n_assert = 0;
   int   n_fail = 0;
   int   ready_pct = 100;
   int   n_trunc = 0;
   int   n_kerr = 0;
   int   exp_trunc = 0;
   int   exp_kerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // pulse counters
   always @(negedge clk) begin
      if (ptrunc === 1'b1) n_trunc++;
      if (kerr === 1'b1) n_kerr++;
   end

   // sink: random backpressure, compare every popped beat in order
   always @(negedge clk) begin
      exp_t e;
      aready = ($urandom_range(99) < ready_pct);
      #1;
      if (avalid && aready) begin
         chk("beat_expected", 64'(expq.size() != 0), 64'd1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("beat", {26'd0, adata, asop, aeop, aempty, ach},
                {26'd0, e.data, e.sop, e.eop, e.empty, e.ch});
         end
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l, input logic [CW-1:0] ds,
                            output int waits);
      @(negedge clk);
      tdata = d; tkeep = k; tlast = l; tdest = ds; tvalid = 1'b1;
      waits = 0;
      #2;
      while (!tready && waits < 300) begin
         @(negedge clk);
         #2;
         waits++;
      end
      chk("accept_in_time", 64'(tready), 64'd1);
      @(posedge clk);
      #1;
      tvalid = 1'b0;
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic s,
                           input logic e, input int emp,
                           input logic [CW-1:0] c);
      exp_t x;
      x.data = d; x.sop = s; x.eop = e; x.empty = EW'(emp); x.ch = c;
      expq.push_back(x);
   endtask

   // Packet of len beats; the model keeps the first MAXL beats, ends a
   // cut packet with EOP/EMPTY=0, takes the channel from the first beat.
   task automatic pkt(input int len, input logic [CW-1:0] dest,
                      input logic [CW-1:0] alt_dest,
                      input logic [KW-1:0] last_keep, input bit bad_keep);
      logic [DW-1:0] d[$];
      logic [KW-1:0] k;
      int nout, w;
      nout = (len > MAXL) ? MAXL : len;
      for (int i = 0; i < len; i++) d.push_back($urandom);
      for (int i = 0; i < nout; i++)
         push_exp(d[i], i == 0, i == nout-1,
                  (i == nout-1 && len <= MAXL) ?
                     KW - $countones(last_keep) : 0, dest);
      if (len > MAXL) exp_trunc++;
      for (int i = 0; i < len; i++) begin
         k = (i == len-1) ? last_keep :
             (bad_keep && i == 0) ? 4'b0011 : 4'hF;
         if (i != len-1 && k != 4'hF) exp_kerr++;
         send_beat(d[i], k, i == len-1, (i == 0) ? dest : alt_dest, w);
         if (i >= MAXL)
            chk("drop_tready", 64'(w), 64'd0);
         else if (ready_pct == 100)
            chk("full_rate", 64'(w), 64'd0);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (expq.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("drain_empty", 64'(expq.size()), 64'd0);
      chk("trunc_count", 64'(n_trunc), 64'(exp_trunc));
      chk("keep_err_count", 64'(n_kerr), 64'(exp_kerr));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk(tag, {47'd0, tready, avalid, asop, aeop, aempty, ach,
                ptrunc, kerr, level}, 64'd0);
      chk({tag, "_data"}, 64'(adata), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [KW-1:0] lk;
      int w, len;

      // reset values and TREADY rising one cycle after release
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("tready_held_after_release", 64'(tready), 64'd0);
      @(negedge clk);
      #2;
      chk("tready_rises", 64'(tready), 64'd1);

      // one-cycle latency on an empty FIFO
      ready_pct = 100;
      d = 32'hCAFE_0001;
      push_exp(d, 1, 1, 0, 2'd2);
      send_beat(d, 4'hF, 1'b1, 2'd2, w);
      chk("latency_valid", {31'd0, avalid, adata}, {31'd0, 1'b1, d});
      drain();

      // 4-beat packet on channel 2
      pkt(4, 2'd2, 2'd2, 4'hF, 0);
      drain();

      // single beat with TKEEP=0011 -> EMPTY=2
      pkt(1, 2'd1, 2'd1, 4'b0011, 0);
      drain();

      // fill: READY low, 10 beats offered, 8 taken, then release
      ready_pct = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++)
         push_exp(32'h1000 + i, (i % 5) == 0, (i % 5) == 4, 0, 2'd3);
      for (int i = 0; i < 8; i++) begin
         send_beat(32'h1000 + i, 4'hF, (i % 5) == 4, 2'd3, w);
         chk("fill_accept", 64'(w), 64'd0);
      end
      @(negedge clk);
      tdata = 32'h1008; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("full_tready_low", 64'(tready), 64'd0);
         chk("full_level", 64'(level), 64'(DEPTH));
         @(negedge clk);
      end
      ready_pct = 100;
      send_beat(32'h1008, 4'hF, 1'b0, 2'd3, w);
      send_beat(32'h1009, 4'hF, 1'b1, 2'd3, w);
      drain();

      // truncation: 12-beat packet then 3-beat packet
      pkt(12, 2'd0, 2'd0, 4'hF, 0);
      pkt(3, 2'd1, 2'd1, 4'b0111, 0);
      drain();

      // TDEST change mid-packet is ignored
      pkt(3, 2'd1, 2'd3, 4'hF, 0);
      drain();

      // keep error on a non-last beat, still forwarded
      pkt(3, 2'd2, 2'd2, 4'b0001, 1);
      drain();

      // reset mid-packet: 2 of 5 beats buffered then lost
      ready_pct = 0;
      @(negedge clk);
      send_beat(32'hDEAD_0000, 4'hF, 1'b0, 2'd1, w);
      send_beat(32'hDEAD_0001, 4'hF, 1'b0, 2'd1, w);
      @(negedge clk);
      chk("mid_level", 64'(level), 64'd2);
      rst_n = 1'b0;
      #2;
      check_reset_outputs("mid_reset");
      expq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ready_pct = 100;
      pkt(3, 2'd2, 2'd2, 4'hF, 0);
      drain();

      // random traffic with backpressure
      ready_pct = 70;
      for (int p = 0; p < 25; p++) begin
         len = $urandom_range(1, 12);
         lk = KW'((1 << ($urandom_range(3) + 1)) - 1);
         pkt(len, CW'($urandom), CW'($urandom), lk, $urandom_range(1));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
